// File: rtl/systolic_array_ctrl_if.sv
// Job/host and PE-array control bundle for the systolic array sequencer.
// master = job source / array side, slave = the sequencer.
interface systolic_array_ctrl_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] num_vec;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic             pe_clear_weight;
  logic             pe_weight_sel;
  logic             pe_mac_enable;
  logic             wet_rd_en;
  logic [ROWS-1:0]  act_rd_en;
  logic [COLS-1:0]  out_valid;

  modport master (
    output start, num_vec, abort,
    input  busy, done, err,
    input  pe_clear_weight, pe_weight_sel,
    input  pe_mac_enable, wet_rd_en,
    input  act_rd_en, out_valid
  );

  modport slave (
    input  start, num_vec, abort,
    output busy, done, err,
    output pe_clear_weight, pe_weight_sel,
    output pe_mac_enable, wet_rd_en,
    output act_rd_en, out_valid
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Weight-stationary systolic array sequencer: clear, weight load,
// skewed activation streaming and per-column output valid flags.
module systolic_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 8
) (
  input logic clk,
  input logic reset_n,
  systolic_array_ctrl_if.slave bus
);

  localparam int TW = LEN_W + $clog2(ROWS + COLS) + 1;
  localparam int WW = $clog2(ROWS);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    COMPUTE,
    DONE
  } state_t;

  state_t          state;
  logic [WW-1:0]   w;
  logic [TW-1:0]   t;
  logic [TW-1:0]   n;
  logic [TW-1:0]   last;
  logic            busy;
  logic            done;
  logic            err;
  logic            clr;
  logic            wsel;
  logic            mac;
  logic            wet;
  logic [ROWS-1:0] act;
  logic [COLS-1:0] outv;

  assign last = n + TW'(ROWS + COLS - 2);

  // Row r pops activations for the N cycles starting at skew r.
  function automatic logic [ROWS-1:0] act_mask(
    input logic [TW-1:0] tt,
    input logic [TW-1:0] nn
  );
    logic [ROWS-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) begin
      m[r] = (tt >= TW'(r)) &&
             (tt <= TW'(r) + nn - TW'(1));
    end
    return m;
  endfunction

  // Column c reaches the bottom ROWS cycles after its first input.
  function automatic logic [COLS-1:0] out_mask(
    input logic [TW-1:0] tt,
    input logic [TW-1:0] nn
  );
    logic [COLS-1:0] m;
    m = '0;
    for (int c = 0; c < COLS; c++) begin
      m[c] = (tt >= TW'(ROWS + c)) &&
             (tt <= TW'(ROWS + c) + nn - TW'(1));
    end
    return m;
  endfunction

  // Sequencer FSM; outputs are registered alongside the state entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      w     <= '0;
      t     <= '0;
      n     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      clr   <= 1'b0;
      wsel  <= 1'b0;
      mac   <= 1'b0;
      wet   <= 1'b0;
      act   <= '0;
      outv  <= '0;
    end else begin
      busy <= 1'b1;
      done <= 1'b0;
      err  <= 1'b0;
      clr  <= 1'b0;
      wsel <= 1'b0;
      mac  <= 1'b0;
      wet  <= 1'b0;
      act  <= '0;
      outv <= '0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (bus.abort) begin
            state <= IDLE;
          end else if (bus.start &&
                       bus.num_vec == '0) begin
            err <= 1'b1;
          end else if (bus.start) begin
            state <= CLEAR;
            n     <= TW'(bus.num_vec);
            busy  <= 1'b1;
            clr   <= 1'b1;
          end
        end
        CLEAR: begin
          state <= LOAD;
          w     <= '0;
          wsel  <= 1'b1;
          wet   <= 1'b1;
        end
        LOAD: begin
          if (w == WW'(ROWS - 1)) begin
            state <= COMPUTE;
            t     <= '0;
            mac   <= 1'b1;
            act   <= act_mask('0, n);
            outv  <= out_mask('0, n);
          end else begin
            w    <= w + WW'(1);
            wsel <= 1'b1;
            wet  <= 1'b1;
          end
        end
        COMPUTE: begin
          if (t == last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            t    <= t + TW'(1);
            mac  <= 1'b1;
            act  <= act_mask(t + TW'(1), n);
            outv <= out_mask(t + TW'(1), n);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (bus.abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
        clr   <= 1'b0;
        wsel  <= 1'b0;
        mac   <= 1'b0;
        wet   <= 1'b0;
        act   <= '0;
        outv  <= '0;
      end
    end
  end

  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.err             = err;
  assign bus.pe_clear_weight = clr;
  assign bus.pe_weight_sel   = wsel;
  assign bus.pe_mac_enable   = mac;
  assign bus.wet_rd_en       = wet;
  assign bus.act_rd_en       = act;
  assign bus.out_valid       = outv;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed + randomized bench for systolic_array_ctrl against a
// cycle-window reference model derived from the job timeline.
module tb_systolic_array_ctrl;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int LW = 8;
  localparam int W  = 7 + R + C;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  systolic_array_ctrl_if #(
    .ROWS(R), .COLS(C), .LEN_W(LW)
  ) bus ();

  systolic_array_ctrl #(
    .ROWS(R), .COLS(C), .LEN_W(LW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] obs();
    return {bus.busy, bus.done, bus.err,
            bus.pe_clear_weight, bus.pe_weight_sel,
            bus.pe_mac_enable, bus.wet_rd_en,
            bus.act_rd_en, bus.out_valid};
  endfunction

  // Expected outputs in cycle j of a job with N=n (start sampled at 0).
  function automatic logic [W-1:0] model(input int j, input int n);
    int d;
    int t;
    logic mac;
    logic wl;
    logic [R-1:0] a;
    logic [C-1:0] o;
    d   = 2 * R + C + n + 1;
    t   = j - (R + 2);
    mac = (j >= R + 2) && (j <= d - 1);
    wl  = (j >= 2) && (j <= R + 1);
    a   = '0;
    o   = '0;
    for (int r = 0; r < R; r++)
      a[r] = mac && (t >= r) && (t <= r + n - 1);
    for (int c = 0; c < C; c++)
      o[c] = mac && (t >= R + c) && (t <= R + c + n - 1);
    return {(j >= 1) && (j <= d), j == d, 1'b0,
            j == 1, wl, mac, wl, a, o};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] o,
                     input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_excl(input string tag);
    logic x;
    x = bus.pe_mac_enable &
        (bus.pe_weight_sel | bus.pe_clear_weight | bus.wet_rd_en);
    chk(tag, 64'(x), 64'(0));
  endtask

  task automatic run_job(input int n,
                         input int abort_at,
                         input int spur_at);
    int d;
    int pa;
    int po;
    logic [W-1:0] e;
    d  = 2 * R + C + n + 1;
    pa = 0;
    po = 0;
    bus.start   = 1'b1;
    bus.num_vec = LW'(n);
    for (int j = 1; j <= d + 1; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) begin
        bus.start   = 1'b0;
        bus.num_vec = LW'($urandom);
      end
      if (abort_at != 0 && j == abort_at + 1) begin
        bus.abort = 1'b0;
        chk($sformatf("abort_n%0d_c%0d", n, j),
            64'(obs()), 64'(0));
        @(posedge clk);
        #1;
        chk($sformatf("abort_idle_n%0d", n),
            64'(obs()), 64'(0));
        return;
      end
      e = model(j, n);
      chk($sformatf("job_n%0d_c%0d", n, j),
          64'(obs()), 64'(e));
      chk_excl($sformatf("excl_n%0d_c%0d", n, j));
      pa += $countones(bus.act_rd_en);
      po += $countones(bus.out_valid);
      if (j == abort_at) bus.abort = 1'b1;
      if (spur_at != 0 && j == spur_at) begin
        bus.start   = 1'b1;
        bus.num_vec = LW'(n + 5);
      end else if (spur_at != 0 && j == spur_at + 1) begin
        bus.start = 1'b0;
      end
    end
    chk($sformatf("act_pop_n%0d", n), 64'(pa), 64'(R * n));
    chk($sformatf("out_pop_n%0d", n), 64'(po), 64'(C * n));
  endtask

  initial begin
    logic [W-1:0] e;
    int n;
    tests       = 0;
    fails       = 0;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.num_vec = '0;
    bus.abort   = 1'b0;
    #1;
    chk("reset_vals", 64'(obs()), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_reset", 64'(obs()), 64'(0));

    run_job(3, 0, 0);
    run_job(2, 0, 0);

    bus.start   = 1'b1;
    bus.num_vec = '0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e = '0;
    e[W-3] = 1'b1;
    chk("err_pulse", 64'(obs()), 64'(e));
    @(posedge clk);
    #1;
    chk("err_once", 64'(obs()), 64'(0));

    bus.start   = 1'b1;
    bus.num_vec = LW'(4);
    bus.abort   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_idle", 64'(obs()), 64'(0));
    @(posedge clk);
    #1;
    chk("start_abort_idle2", 64'(obs()), 64'(0));

    run_job(3, 7, 0);
    run_job(1, 0, 0);
    run_job(3, 0, 8);

    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(1, 10));
      if ($urandom_range(0, 1) == 1)
        run_job(n, 0, R + 2 + int'($urandom_range(0, n)));
      else
        run_job(n, 0, 0);
    end

    bus.start   = 1'b1;
    bus.num_vec = LW'(3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_load", 64'(bus.pe_weight_sel), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 64'(obs()), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_rst2", 64'(obs()), 64'(0));

    run_job(255, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_array_ctrl.md
# systolic_array_ctrl

Sequencer for the ROWS×COLS weight-stationary systolic PE array. On each job it:
- clears the PE weight registers;
- shifts one weight row per cycle down the columns;
- streams N activation vectors into the rows with a one-cycle-per-row skew;
- flags when each column's bottom output is valid.

It sits between the job/host interface and the array, and it drives the array-wide PE control lines plus the read enables of the weight and activation buffers.

## Interface
- ROWS, 4, array rows (≥2)
- COLS, 4, array columns (≥2)
- LEN_W, 8, width of vector count
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  job request, sampled in IDLE only
- num_vec  in  LEN_W  N, activation vectors in job; sampled with start
- abort  in  1  cancel current job
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal job end
- err  out  1  one-cycle pulse: start rejected (num_vec==0)
- pe_clear_weight  out  1  clear all PE weight regs
- pe_weight_sel  out  1  1 = weight-load mode, 0 = MAC mode
- pe_mac_enable  out  1  MAC enable to all PEs
- wet_rd_en  out  1  pop one weight row from weight buffer
- act_rd_en  out  ROWS  per-row activation pop
- out_valid  out  COLS  per-column result valid at array bottom

## Operation
- States: IDLE, CLEAR, LOAD, COMPUTE, DONE.
- IDLE to CLEAR:
  - Taken on start=1, num_vec≠0 and abort=0; N is latched.
  - start=1 with num_vec=0: err=1 for one cycle, state stays IDLE.
- CLEAR: one cycle with pe_clear_weight=1. Next state is LOAD.
- LOAD: exactly ROWS cycles with pe_weight_sel=1 and wet_rd_en=1. Counter w runs 0..ROWS-1. Next state is COMPUTE.
- COMPUTE:
  - Cycle counter t runs 0..N+ROWS+COLS-2, i.e. N+ROWS+COLS-1 cycles.
  - pe_mac_enable=1 and pe_weight_sel=0 throughout.
  - act_rd_en[r]=1 exactly when r ≤ t ≤ r+N-1.
  - out_valid[c]=1 exactly when ROWS+c ≤ t ≤ ROWS+c+N-1.
  - Next state is DONE.
- DONE: one cycle with done=1, then IDLE.
- All outputs are registered and are zero when not asserted by the current state. pe_clear_weight, pe_weight_sel and wet_rd_en are mutually exclusive with pe_mac_enable.
- Counter t is LEN_W+$clog2(ROWS+COLS)+1 bits. Compares use full width, so there is no wrap for N = 2^LEN_W−1.
- abort=1 in any busy state: next cycle is IDLE with all outputs 0, and there is no done pulse. Array weights are left as they are; the next job's CLEAR handles them.
- abort and start both high in IDLE: abort wins, start is ignored, no err.
- start while busy: ignored. N is not re-latched.
- reset_n low at any time (including mid-job): state goes to IDLE immediately, all counters and outputs go to 0.

## Timing
- Cycle 0 is the edge where start is sampled.
- CLEAR at cycle 1.
- LOAD at cycles 2..ROWS+1.
- COMPUTE at cycles ROWS+2..2·ROWS+COLS+N.
- done at cycle 2·ROWS+COLS+N+1.
- busy falls the cycle after done. A new start is accepted on the cycle after done, and is therefore registered at that same edge.
- Start-to-done latency is 2·ROWS+COLS+N+1 cycles.
- Reset values: busy, done, err, pe_clear_weight, pe_weight_sel, pe_mac_enable, wet_rd_en are 0; act_rd_en = 0, out_valid = 0.

## Test plan
- ROWS=COLS=4, start with N=3 at cycle 0:
  - pe_clear_weight at cycle 1;
  - pe_weight_sel/wet_rd_en at cycles 2–5;
  - act_rd_en[0] at cycles 6–8, act_rd_en[3] at cycles 9–11;
  - out_valid[0] at cycles 10–12, out_valid[3] at cycles 13–15;
  - done at cycle 16;
  - a start in the cycle after done is registered at that edge; CLEAR follows on the next cycle.
- start with num_vec=0: err pulses once, busy stays 0, no PE control toggles.
- abort at cycle 7 of an N=3 job: all outputs 0 from cycle 8, no done. A following N=1 job completes with done at cycle +14.
- start pulsed during COMPUTE, and start+abort together in IDLE: both are ignored; no state change and no err.
- reset_n asserted mid-LOAD: every output 0 asynchronously. After release, an N=255 job runs with exact act_rd_en/out_valid windows (no counter wrap), done at cycle 268.
- Every cycle across random jobs: pe_mac_enable is never high together with pe_weight_sel, pe_clear_weight or wet_rd_en. The popcount of act_rd_en over a job is ROWS·N, and of out_valid is COLS·N.
